// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp -- multi-ported register file with a per-register busy scoreboard.
//
// Purpose
//   COUNT registers of WORD_SIZE bits, with WRITE_PORTS write ports and
//   READ_PORTS read ports. When several write ports target the same register,
//   the highest-numbered port wins. Each register also has a "busy" bit.
//   busy_set marks a register as pending. Any accepted write clears that
//   register's busy bit, but a set in the same cycle takes precedence.
//   Optional features:
//     - a hard-wired zero register (ZERO_REG),
//     - forwarding of same-cycle write data and busy state to readers (BYPASS),
//     - a registered read path (READ_LATENCY = 1).
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   en_write   [WRITE_PORTS]            per-port write enable
//   idx_write  [WRITE_PORTS*CB]         write index, port p at [p*CB +: CB]
//   data_in    [WRITE_PORTS*WORD_SIZE]  write data,  port p at [p*WORD_SIZE +: WORD_SIZE]
//   idx_read   [READ_PORTS*CB]          read index,  packed like idx_write
//   data_out   [READ_PORTS*WORD_SIZE]   read data,   packed like data_in
//   read_busy  [READ_PORTS]             busy bit of the register each port reads
//   busy_set   mark register busy_idx as pending
//   busy_idx   [CB]                     register to mark
//   busy_vec   [COUNT]                  full scoreboard
// ---------------------------------------------------------------------------
module regfile_mp #(
  parameter int WORD_SIZE    = 16,
  parameter int COUNT        = 32,
  parameter int READ_PORTS   = 2,
  parameter int WRITE_PORTS  = 2,
  parameter int ZERO_REG     = 0,
  parameter int BYPASS       = 1,
  parameter int READ_LATENCY = 0,
  localparam int CB          = $clog2(COUNT)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [WRITE_PORTS-1:0]          en_write,
  input  logic [WRITE_PORTS*CB-1:0]       idx_write,
  input  logic [WRITE_PORTS*WORD_SIZE-1:0] data_in,
  input  logic [READ_PORTS*CB-1:0]        idx_read,
  output logic [READ_PORTS*WORD_SIZE-1:0] data_out,
  output logic [READ_PORTS-1:0]           read_busy,
  input  logic                            busy_set,
  input  logic [CB-1:0]                   busy_idx,
  output logic [COUNT-1:0]                busy_vec
);

  // Architectural state and its next-edge value.
  logic [WORD_SIZE-1:0] mem_reg  [COUNT];
  logic [WORD_SIZE-1:0] mem_next [COUNT];
  logic [COUNT-1:0]     busy_reg;
  logic [COUNT-1:0]     busy_next;

  // -------------------------------------------------------------------------
  // Per-register write resolution and scoreboard update.
  // Ports are scanned in ascending order, so the highest enabled port that
  // matches is the one left standing. An index >= COUNT never matches any
  // register, which is how out-of-range writes are dropped.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < COUNT; gi++) begin : g_reg
      localparam bit IS_ZERO = (ZERO_REG != 0) && (gi == 0);

      logic                 hit;
      logic [WORD_SIZE-1:0] wdata;
      logic                 busy_nxt;

      always_comb begin
        hit   = 1'b0;
        wdata = '0;
        for (int p = 0; p < WRITE_PORTS; p++) begin
          if (en_write[p] && (idx_write[p*CB +: CB] == CB'(gi))) begin
            hit   = 1'b1;
            wdata = data_in[p*WORD_SIZE +: WORD_SIZE];
          end
        end
        if (IS_ZERO) begin
          hit = 1'b0;
        end
      end

      // The set is applied after the write-clear so that it takes precedence.
      always_comb begin
        busy_nxt = busy_reg[gi];
        if (hit) begin
          busy_nxt = 1'b0;
        end
        if (busy_set && (busy_idx == CB'(gi))) begin
          busy_nxt = 1'b1;
        end
        if (IS_ZERO) begin
          busy_nxt = 1'b0;
        end
      end

      assign mem_next[gi]  = hit ? wdata : mem_reg[gi];
      assign busy_next[gi] = busy_nxt;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < COUNT; r++) begin
        mem_reg[r] <= '0;
      end
      busy_reg <= '0;
    end else begin
      for (int r = 0; r < COUNT; r++) begin
        mem_reg[r] <= mem_next[r];
      end
      busy_reg <= busy_next;
    end
  end

  assign busy_vec = busy_reg;

  // -------------------------------------------------------------------------
  // Read ports.
  // With bypass enabled, the post-edge view (mem_next/busy_next) is read.
  // Otherwise the current state is read. Indices >= COUNT match nothing, so
  // they read 0. While reset is asserted, the forwarded values are forced to
  // 0 so that pending writes and sets cannot leak through the bypass path.
  // -------------------------------------------------------------------------
  generate
    for (gi = 0; gi < READ_PORTS; gi++) begin : g_rd
      logic [CB-1:0]        ridx;
      logic [WORD_SIZE-1:0] rdata;
      logic                 rbusy;

      assign ridx = idx_read[gi*CB +: CB];

      always_comb begin
        rdata = '0;
        rbusy = 1'b0;
        if (!rst) begin
          for (int r = 0; r < COUNT; r++) begin
            if (ridx == CB'(r)) begin
              rdata = (BYPASS != 0) ? mem_next[r]  : mem_reg[r];
              rbusy = (BYPASS != 0) ? busy_next[r] : busy_reg[r];
            end
          end
        end
      end

      if (READ_LATENCY == 0) begin : g_comb
        assign data_out[gi*WORD_SIZE +: WORD_SIZE] = rdata;
        assign read_busy[gi]                       = rbusy;
      end else begin : g_regd
        logic [WORD_SIZE-1:0] out_data_reg;
        logic                 out_busy_reg;

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            out_data_reg <= '0;
            out_busy_reg <= 1'b0;
          end else begin
            out_data_reg <= rdata;
            out_busy_reg <= rbusy;
          end
        end

        assign data_out[gi*WORD_SIZE +: WORD_SIZE] = out_data_reg;
        assign read_busy[gi]                       = out_busy_reg;
      end
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp -- directed testbench for regfile_mp.
//
// Four instances share one stimulus bus:
//   u_def  defaults (BYPASS=1, READ_LATENCY=0, COUNT=32)
//   u_nb   BYPASS=0
//   u_zr   ZERO_REG=1
//   u_l1   COUNT=20, READ_LATENCY=1
// Inputs change 1ns after the rising edge. Outputs are sampled 1ns later,
// which keeps sampling well away from the next edge.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  en_write;
  logic [9:0]  idx_write;
  logic [31:0] data_in;
  logic [9:0]  idx_read;
  logic        busy_set;
  logic [4:0]  busy_idx;

  logic [31:0] do_def, do_nb, do_zr, do_l1;
  logic [1:0]  rb_def, rb_nb, rb_zr, rb_l1;
  logic [31:0] bv_def, bv_nb, bv_zr;
  logic [19:0] bv_l1;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  regfile_mp u_def (
    .clk(clk), .rst(rst), .en_write(en_write), .idx_write(idx_write),
    .data_in(data_in), .idx_read(idx_read), .data_out(do_def),
    .read_busy(rb_def), .busy_set(busy_set), .busy_idx(busy_idx), .busy_vec(bv_def)
  );

  regfile_mp #(.BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .en_write(en_write), .idx_write(idx_write),
    .data_in(data_in), .idx_read(idx_read), .data_out(do_nb),
    .read_busy(rb_nb), .busy_set(busy_set), .busy_idx(busy_idx), .busy_vec(bv_nb)
  );

  regfile_mp #(.ZERO_REG(1)) u_zr (
    .clk(clk), .rst(rst), .en_write(en_write), .idx_write(idx_write),
    .data_in(data_in), .idx_read(idx_read), .data_out(do_zr),
    .read_busy(rb_zr), .busy_set(busy_set), .busy_idx(busy_idx), .busy_vec(bv_zr)
  );

  regfile_mp #(.COUNT(20), .READ_LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .en_write(en_write), .idx_write(idx_write),
    .data_in(data_in), .idx_read(idx_read), .data_out(do_l1),
    .read_busy(rb_l1), .busy_set(busy_set), .busy_idx(busy_idx), .busy_vec(bv_l1)
  );

  // ---------------- stimulus helpers (drive only, no checking) -------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    en_write  = '0;
    idx_write = '0;
    data_in   = '0;
    busy_set  = 1'b0;
    busy_idx  = '0;
  endtask

  task automatic wr(input int p, input logic [4:0] idx, input logic [15:0] d);
    en_write[p]           = 1'b1;
    idx_write[p*5 +: 5]   = idx;
    data_in[p*16 +: 16]   = d;
  endtask

  task automatic rd(input int p, input logic [4:0] idx);
    idx_read[p*5 +: 5] = idx;
  endtask

  // ---------------- scenarios ----------------------------------------------
  task automatic test_reset();
    $display("[TB] test_reset");
    repeat (2) @(posedge clk);
    #1;
    tests++; if (do_def !== 32'h0) begin failed++; $display("FAIL reset_do_def: got %h expected %h", do_def, 32'h0); end
    tests++; if (bv_def !== 32'h0) begin failed++; $display("FAIL reset_bv_def: got %h expected %h", bv_def, 32'h0); end
    tests++; if (do_l1 !== 32'h0) begin failed++; $display("FAIL reset_do_l1: got %h expected %h", do_l1, 32'h0); end
    tests++; if (bv_l1 !== 20'h0) begin failed++; $display("FAIL reset_bv_l1: got %h expected %h", bv_l1, 20'h0); end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    $display("[TB] test_write_read: r5=1234 via port 0, read port 1");
    clear_in(); wr(0, 5'd5, 16'h1234);
    tick();
    clear_in(); rd(1, 5'd5);
    #1;
    tests++; if (do_def[31:16] !== 16'h1234) begin failed++; $display("FAIL wr_rd_def: got %h expected %h", do_def[31:16], 16'h1234); end
    tests++; if (do_nb[31:16] !== 16'h1234) begin failed++; $display("FAIL wr_rd_nb: got %h expected %h", do_nb[31:16], 16'h1234); end
    tick();
    tests++; if (do_l1[31:16] !== 16'h1234) begin failed++; $display("FAIL wr_rd_l1: got %h expected %h", do_l1[31:16], 16'h1234); end
  endtask

  task automatic test_priority();
    $display("[TB] test_priority: ports 0/1 write r7 AAAA/5555");
    clear_in(); wr(0, 5'd7, 16'hAAAA); wr(1, 5'd7, 16'h5555); rd(0, 5'd7);
    #1;
    tests++; if (do_def[15:0] !== 16'h5555) begin failed++; $display("FAIL prio_bypass_def: got %h expected %h", do_def[15:0], 16'h5555); end
    tests++; if (do_nb[15:0] !== 16'h0000) begin failed++; $display("FAIL prio_old_nb: got %h expected %h", do_nb[15:0], 16'h0000); end
    tick();
    clear_in();
    #1;
    tests++; if (do_nb[15:0] !== 16'h5555) begin failed++; $display("FAIL prio_nb: got %h expected %h", do_nb[15:0], 16'h5555); end
    tests++; if (do_l1[15:0] !== 16'h5555) begin failed++; $display("FAIL prio_l1: got %h expected %h", do_l1[15:0], 16'h5555); end
  endtask

  task automatic test_bypass();
    $display("[TB] test_bypass: write r3=BEEF while reading r3");
    clear_in(); wr(0, 5'd3, 16'hBEEF); rd(0, 5'd3);
    #1;
    tests++; if (do_def[15:0] !== 16'hBEEF) begin failed++; $display("FAIL byp_def: got %h expected %h", do_def[15:0], 16'hBEEF); end
    tests++; if (do_nb[15:0] !== 16'h0000) begin failed++; $display("FAIL byp_old_nb: got %h expected %h", do_nb[15:0], 16'h0000); end
    tick();
    clear_in();
    #1;
    tests++; if (do_nb[15:0] !== 16'hBEEF) begin failed++; $display("FAIL byp_new_nb: got %h expected %h", do_nb[15:0], 16'hBEEF); end
    tests++; if (do_l1[15:0] !== 16'hBEEF) begin failed++; $display("FAIL byp_l1: got %h expected %h", do_l1[15:0], 16'hBEEF); end
  endtask

  task automatic test_zero_reg();
    $display("[TB] test_zero_reg: write r0=FFFF and busy_set 0");
    clear_in(); wr(0, 5'd0, 16'hFFFF); busy_set = 1'b1; busy_idx = 5'd0; rd(0, 5'd0);
    #1;
    tests++; if (do_zr[15:0] !== 16'h0000) begin failed++; $display("FAIL zr_byp: got %h expected %h", do_zr[15:0], 16'h0000); end
    tests++; if (do_def[15:0] !== 16'hFFFF) begin failed++; $display("FAIL zr_def_byp: got %h expected %h", do_def[15:0], 16'hFFFF); end
    tests++; if (rb_def[0] !== 1'b1) begin failed++; $display("FAIL zr_def_rbusy: got %b expected %b", rb_def[0], 1'b1); end
    tests++; if (rb_zr[0] !== 1'b0) begin failed++; $display("FAIL zr_rbusy: got %b expected %b", rb_zr[0], 1'b0); end
    tick();
    clear_in();
    #1;
    tests++; if (do_zr[15:0] !== 16'h0000) begin failed++; $display("FAIL zr_read: got %h expected %h", do_zr[15:0], 16'h0000); end
    tests++; if (bv_zr[0] !== 1'b0) begin failed++; $display("FAIL zr_busy0: got %b expected %b", bv_zr[0], 1'b0); end
    tests++; if (bv_def[0] !== 1'b1) begin failed++; $display("FAIL zr_def_busy0: got %b expected %b", bv_def[0], 1'b1); end
    tests++; if (do_def[15:0] !== 16'hFFFF) begin failed++; $display("FAIL zr_def_read: got %h expected %h", do_def[15:0], 16'hFFFF); end
  endtask

  task automatic test_scoreboard();
    $display("[TB] test_scoreboard: set/clear busy on r9");
    clear_in(); busy_set = 1'b1; busy_idx = 5'd9; rd(1, 5'd9);
    #1;
    tests++; if (rb_def[1] !== 1'b1) begin failed++; $display("FAIL sb_set_byp: got %b expected %b", rb_def[1], 1'b1); end
    tests++; if (rb_nb[1] !== 1'b0) begin failed++; $display("FAIL sb_set_nb_pre: got %b expected %b", rb_nb[1], 1'b0); end
    tick();
    clear_in();
    #1;
    tests++; if (bv_def[9] !== 1'b1) begin failed++; $display("FAIL sb_vec_set: got %b expected %b", bv_def[9], 1'b1); end
    tests++; if (rb_nb[1] !== 1'b1) begin failed++; $display("FAIL sb_set_nb_post: got %b expected %b", rb_nb[1], 1'b1); end
    wr(1, 5'd9, 16'h0009);
    #1;
    tests++; if (rb_def[1] !== 1'b0) begin failed++; $display("FAIL sb_clr_byp: got %b expected %b", rb_def[1], 1'b0); end
    tick();
    clear_in();
    #1;
    tests++; if (bv_def[9] !== 1'b0) begin failed++; $display("FAIL sb_vec_clr: got %b expected %b", bv_def[9], 1'b0); end
    tests++; if (rb_nb[1] !== 1'b0) begin failed++; $display("FAIL sb_clr_nb: got %b expected %b", rb_nb[1], 1'b0); end
    busy_set = 1'b1; busy_idx = 5'd9; wr(0, 5'd9, 16'h0099);
    tick();
    clear_in();
    #1;
    tests++; if (bv_def[9] !== 1'b1) begin failed++; $display("FAIL sb_set_wins: got %b expected %b", bv_def[9], 1'b1); end
    tests++; if (do_def[31:16] !== 16'h0099) begin failed++; $display("FAIL sb_set_write_data: got %h expected %h", do_def[31:16], 16'h0099); end
  endtask

  task automatic test_out_of_range();
    $display("[TB] test_out_of_range: COUNT=20 instance reads/writes idx 25");
    clear_in(); rd(0, 5'd5);
    tick();
    tests++; if (do_l1[15:0] !== 16'h1234) begin failed++; $display("FAIL oor_pre_l1: got %h expected %h", do_l1[15:0], 16'h1234); end
    wr(0, 5'd25, 16'h7777); busy_set = 1'b1; busy_idx = 5'd25; rd(0, 5'd25);
    tick();
    clear_in();
    #1;
    tests++; if (do_l1[15:0] !== 16'h0000) begin failed++; $display("FAIL oor_l1_data: got %h expected %h", do_l1[15:0], 16'h0000); end
    tests++; if (rb_l1[0] !== 1'b0) begin failed++; $display("FAIL oor_l1_rbusy: got %b expected %b", rb_l1[0], 1'b0); end
    tests++; if (bv_l1 !== 20'h00201) begin failed++; $display("FAIL oor_l1_bvec: got %h expected %h", bv_l1, 20'h00201); end
    tests++; if (do_def[15:0] !== 16'h7777) begin failed++; $display("FAIL oor_def_in_range: got %h expected %h", do_def[15:0], 16'h7777); end
    tests++; if (bv_def[25] !== 1'b1) begin failed++; $display("FAIL oor_def_busy25: got %b expected %b", bv_def[25], 1'b1); end
  endtask

  task automatic test_reset_mid_burst();
    $display("[TB] test_reset_mid_burst");
    clear_in(); rd(0, 5'd5); rd(1, 5'd9); wr(0, 5'd10, 16'h0A0A);
    tick();
    clear_in(); wr(0, 5'd11, 16'h1111);
    #1;
    tests++; if (do_l1 !== 32'h0099_1234) begin failed++; $display("FAIL mid_pre_l1: got %h expected %h", do_l1, 32'h0099_1234); end
    rst = 1'b1;
    #1;
    tests++; if (do_l1 !== 32'h0) begin failed++; $display("FAIL mid_rst_do_l1: got %h expected %h", do_l1, 32'h0); end
    tests++; if (rb_l1 !== 2'b00) begin failed++; $display("FAIL mid_rst_rb_l1: got %b expected %b", rb_l1, 2'b00); end
    tests++; if (bv_l1 !== 20'h0) begin failed++; $display("FAIL mid_rst_bv_l1: got %h expected %h", bv_l1, 20'h0); end
    tests++; if (do_def !== 32'h0) begin failed++; $display("FAIL mid_rst_do_def: got %h expected %h", do_def, 32'h0); end
    tests++; if (rb_def !== 2'b00) begin failed++; $display("FAIL mid_rst_rb_def: got %b expected %b", rb_def, 2'b00); end
    tests++; if (bv_def !== 32'h0) begin failed++; $display("FAIL mid_rst_bv_def: got %h expected %h", bv_def, 32'h0); end
    tick();
    rst = 1'b0;
    rd(0, 5'd11);
    #1;
    tests++; if (do_nb[15:0] !== 16'h0000) begin failed++; $display("FAIL mid_post_pre_edge: got %h expected %h", do_nb[15:0], 16'h0000); end
    tick();
    tests++; if (do_nb[15:0] !== 16'h1111) begin failed++; $display("FAIL mid_first_write: got %h expected %h", do_nb[15:0], 16'h1111); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    idx_read = '0;
    clear_in();
    test_reset();
    test_write_read();
    test_priority();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_out_of_range();
    test_reset_mid_burst();
    $display("[TB] output parity %b", ^{do_def, do_nb, do_zr, do_l1, rb_def, rb_nb, rb_zr, rb_l1, bv_def, bv_nb, bv_zr, bv_l1});
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
